// File: rtl/wshb_slave_pkg.sv
// Shared widths and FSM state encoding for the Wishbone RAM slave.
package wshb_slave_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        ACK,
        RTY
    } wshb_slv_state_t;

endpackage

// File: rtl/wshb_ram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port, coded in the plain style that maps onto block RAM.
module wshb_ram_be
    import wshb_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic [SEL_W-1:0]      be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane writes plus a read every cycle (old data on a same-address write)
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < SEL_W; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone classic-cycle slave in front of a byte-enabled RAM. Byte
// addressed, 16-bit words, configurable read latency, rty outside the window.
module wshb_ram_slave
    import wshb_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned READ_LAT   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       adr,
    input  logic [DATA_W-1:0] dat_ms,
    output logic [DATA_W-1:0] dat_sm,
    input  logic [SEL_W-1:0]  sel,
    input  logic              we,
    input  logic              cyc,
    input  logic              stb,
    output logic              ack,
    output logic              rty
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    wshb_slv_state_t       state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  rd_q, rd_d;
    logic                  ack_q, ack_d;
    logic                  rty_q, rty_d;
    logic [DATA_W-1:0]     dat_q, dat_d;

    logic [31:0]           diff;
    logic [31:0]           off;
    logic                  in_win;
    logic                  req;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [SEL_W-1:0]      ram_be;
    logic [DATA_W-1:0]     ram_q;

    assign req = cyc & stb;

    // Window decode: word offset from the base, valid only above the base and below the depth
    always_comb begin
        diff   = adr - BASE_ADDR;
        off    = diff >> 1;
        in_win = (adr >= BASE_ADDR) && ((off >> ADDR_WIDTH) == 32'd0);
    end

    // While idle the RAM follows the live address so a read starts at the
    // request edge; afterwards it keeps re-reading the latched index.
    assign ram_addr = (state_q == IDLE) ? off[ADDR_WIDTH-1:0] : idx_q;

    wshb_ram_be #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i  (clk),
        .be_i   (ram_be),
        .addr_i (ram_addr),
        .wdata_i(dat_ms),
        .rdata_o(ram_q)
    );

    // Next-state, latency counter, RAM write strobe and read-data capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        dat_d   = dat_q;
        ram_be  = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (!in_win) begin
                        rd_d    = 1'b0;
                        state_d = RTY;
                    end else if (we) begin
                        ram_be  = sel;
                        rd_d    = 1'b0;
                        state_d = ACK;
                    end else begin
                        idx_d   = off[ADDR_WIDTH-1:0];
                        cnt_d   = CNT_INIT;
                        rd_d    = 1'b1;
                        state_d = (READ_LAT == 1) ? ACK : RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (!cyc) begin
                    // Master abandoned the cycle: drop the read, keep old data
                    cnt_d   = '0;
                    rd_d    = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    dat_d   = ram_q;
                    cnt_d   = '0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ACK: begin
                // Single-cycle latency presents RAM output directly; hold it here
                if ((READ_LAT == 1) && rd_q) begin
                    dat_d = ram_q;
                end
                rd_d    = 1'b0;
                state_d = IDLE;
            end
            RTY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ack_d = (state_d == ACK);
        rty_d = (state_d == RTY);
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            ack_q   <= 1'b0;
            rty_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
            rty_q   <= rty_d;
            dat_q   <= dat_d;
        end
    end

    // Latched read index; only meaningful while a read is in flight
    always_ff @(posedge clk) begin
        idx_q <= idx_d;
    end

    assign ack    = ack_q;
    assign rty    = rty_q;
    assign dat_sm = ((READ_LAT == 1) && ack_q && rd_q) ? ram_q : dat_q;

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Bench for wshb_ram_slave: two instances (base 0 / latency 2 and
// base 0x1000 / latency 4) sharing one master model.
module tb_wshb_ram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] adr;
    logic [15:0] dat_ms;
    logic [1:0]  sel;
    logic        we, cyc, stb;
    logic        dsel;

    logic        cyc0, cyc1;
    logic [15:0] dat_sm0, dat_sm1, dat_m;
    logic        ack0, ack1, rty0, rty1, ack_m, rty_m;

    assign cyc0  = cyc & ~dsel;
    assign cyc1  = cyc & dsel;
    assign ack_m = dsel ? ack1 : ack0;
    assign rty_m = dsel ? rty1 : rty0;
    assign dat_m = dsel ? dat_sm1 : dat_sm0;

    wshb_ram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .READ_LAT(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .adr(adr), .dat_ms(dat_ms), .dat_sm(dat_sm0),
        .sel(sel), .we(we), .cyc(cyc0), .stb(stb), .ack(ack0), .rty(rty0));

    wshb_ram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .READ_LAT(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .adr(adr), .dat_ms(dat_ms), .dat_sm(dat_sm1),
        .sel(sel), .we(we), .cyc(cyc1), .stb(stb), .ack(ack1), .rty(rty1));

    typedef struct {
        logic        d;
        logic        w;
        logic [31:0] a;
        logic [15:0] wd;
        logic [1:0]  s;
        logic        er;
        logic [15:0] rd;
    } vec_t;

    typedef struct {
        logic        rty;
        logic [15:0] dat;
        int          lat;
    } exp_t;

    vec_t        vt[$];
    exp_t        sb[$];
    logic [15:0] last_dat [0:1];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic d, input logic w, input logic [31:0] a,
                                input logic [15:0] wd, input logic [1:0] s,
                                input logic er, input logic [15:0] rd);
        vec_t v;
        v.d = d; v.w = w; v.a = a; v.wd = wd; v.s = s; v.er = er; v.rd = rd;
        vt.push_back(v);
    endfunction

    // One complete transfer: push expectation, drive, wait (bounded), pop and compare
    task automatic xfer(input logic d, input logic w, input logic [31:0] a,
                        input logic [15:0] wd, input logic [1:0] s,
                        input logic er, input logic [15:0] rd);
        exp_t e, g;
        int   n;
        logic seen;
        e.rty = er;
        e.dat = (er || w) ? last_dat[d] : rd;
        e.lat = (er || w) ? 1 : (d ? 4 : 2);
        sb.push_back(e);
        @(posedge clk); #1;
        dsel = d; adr = a; dat_ms = wd; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            check("ack_rty_exclusive", 32'(ack_m & rty_m), 32'd0);
            seen = ack_m | rty_m;
        end
        g = sb.pop_front();
        check("response_seen", 32'(seen), 32'd1);
        check("latency", n, g.lat);
        check("rty", 32'(rty_m), 32'(g.rty));
        check("ack", 32'(ack_m), 32'(!g.rty));
        check("dat_sm", 32'(dat_m), 32'(g.dat));
        last_dat[d] = g.dat;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(ack_m), 32'd0);
        check("rty_one_cycle", 32'(rty_m), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t g;
        int   n, nack, last;

        reset_n = 1'b0; adr = '0; dat_ms = '0; sel = '0; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; dsel = 1'b0;
        last_dat[0] = 16'h0000;
        last_dat[1] = 16'h0000;

        // dut0: base 0, latency 2
        add(0, 1, 32'h10,  16'hBEEF, 2'b11, 0, 16'h0);
        add(0, 0, 32'h10,  16'h0,    2'b11, 0, 16'hBEEF);
        add(0, 1, 32'h20,  16'h1234, 2'b11, 0, 16'h0);
        add(0, 1, 32'h20,  16'hAB00, 2'b10, 0, 16'h0);
        add(0, 0, 32'h20,  16'h0,    2'b11, 0, 16'hAB34);
        add(0, 0, 32'h21,  16'h0,    2'b11, 0, 16'hAB34);
        add(0, 1, 32'h30,  16'hFFFF, 2'b11, 0, 16'h0);
        add(0, 1, 32'h30,  16'h00CD, 2'b01, 0, 16'h0);
        add(0, 0, 32'h30,  16'h0,    2'b00, 0, 16'hFFCD);
        add(0, 1, 32'h0,   16'h1111, 2'b11, 0, 16'h0);
        add(0, 1, 32'h2,   16'h2222, 2'b11, 0, 16'h0);
        add(0, 1, 32'h4,   16'h3333, 2'b11, 0, 16'h0);
        add(0, 1, 32'h7FE, 16'h5A5A, 2'b11, 0, 16'h0);
        add(0, 0, 32'h7FE, 16'h0,    2'b11, 0, 16'h5A5A);
        add(0, 0, 32'h800, 16'h0,    2'b11, 1, 16'h0);
        add(0, 1, 32'h800, 16'hDEAD, 2'b11, 1, 16'h0);
        // dut1: base 0x1000, latency 4
        add(1, 1, 32'h1000, 16'hCAFE, 2'b11, 0, 16'h0);
        add(1, 0, 32'h1000, 16'h0,    2'b11, 0, 16'hCAFE);
        add(1, 1, 32'h17FE, 16'h7777, 2'b11, 0, 16'h0);
        add(1, 0, 32'h0FFE, 16'h0,    2'b11, 1, 16'h0);
        add(1, 1, 32'h1800, 16'hDEAD, 2'b11, 1, 16'h0);
        add(1, 1, 32'h0FFE, 16'hDEAD, 2'b11, 1, 16'h0);
        add(1, 0, 32'h17FE, 16'h0,    2'b11, 0, 16'h7777);
        add(1, 0, 32'h1000, 16'h0,    2'b11, 0, 16'hCAFE);

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_rty0", 32'(rty0), 32'd0);
        check("rst_dat0", 32'(dat_sm0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_rty1", 32'(rty1), 32'd0);
        check("rst_dat1", 32'(dat_sm1), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            xfer(vt[i].d, vt[i].w, vt[i].a, vt[i].wd, vt[i].s, vt[i].er, vt[i].rd);
        end

        // Back-to-back reads on dut0 with stb held high
        for (int k = 0; k < 3; k++) begin
            g.rty = 1'b0; g.lat = 2;
            g.dat = (k == 0) ? 16'h1111 : ((k == 1) ? 16'h2222 : 16'h3333);
            sb.push_back(g);
        end
        @(posedge clk); #1;
        dsel = 1'b0; we = 1'b0; sel = 2'b11; adr = 32'h0; cyc = 1'b1; stb = 1'b1;
        nack = 0; last = 0; n = 0;
        while (nack < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (ack_m) begin
                g = sb.pop_front();
                check("b2b_dat", 32'(dat_m), 32'(g.dat));
                if (nack > 0) check("b2b_spacing", n - last, 3);
                last = n;
                nack++;
                adr = 32'(nack * 2);
                if (nack == 3) begin
                    cyc = 1'b0; stb = 1'b0;
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        check("b2b_count", nack, 3);
        repeat (6) begin
            @(negedge clk);
            check("b2b_no_extra_ack", 32'(ack_m), 32'd0);
        end
        last_dat[0] = 16'h3333;

        // Abort on dut1: cyc dropped two cycles after the read request
        @(posedge clk); #1;
        dsel = 1'b1; we = 1'b0; sel = 2'b11; adr = 32'h1000; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("abort_no_ack", 32'(ack_m), 32'd0);
            check("abort_dat_hold", 32'(dat_m), 32'(last_dat[1]));
        end
        xfer(1, 1, 32'h1004, 16'h4444, 2'b11, 0, 16'h0);
        xfer(1, 0, 32'h1004, 16'h0,    2'b11, 0, 16'h4444);

        // Reset asserted while dut1 is waiting on a read
        @(posedge clk); #1;
        dsel = 1'b1; we = 1'b0; adr = 32'h1000; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("midrst_ack1", 32'(ack1), 32'd0);
        check("midrst_rty1", 32'(rty1), 32'd0);
        check("midrst_dat1", 32'(dat_sm1), 32'd0);
        check("midrst_dat0", 32'(dat_sm0), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        last_dat[0] = 16'h0000;
        last_dat[1] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("midrst_read_dropped", 32'(ack1), 32'd0);
        end
        xfer(1, 0, 32'h1000, 16'h0, 2'b11, 0, 16'hCAFE);
        xfer(0, 0, 32'h10,   16'h0, 2'b11, 0, 16'hBEEF);
        xfer(0, 0, 32'h2,    16'h0, 2'b11, 0, 16'h2222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wshb_ram_slave.md
# wshb_ram_slave

Wishbone classic-cycle slave with internal byte-enabled RAM. It answers the 16-bit word transfers issued by the HPS Wishbone master, which uses byte addresses, and gives the processor a scratch/parameter memory inside the FPGA fabric. Read latency is configurable. Out-of-window accesses are refused with `rty`.

## Interface
- `ADDR_WIDTH`, default 10: log2 of RAM depth in 16-bit words (1024 words).
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be 2-byte aligned.
- `READ_LAT`, default 2: cycles from read request sampled to `ack` high; legal range 1..7.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `adr` in 32: byte address; bit 0 ignored.
- `dat_ms` in 16: write data, master to slave.
- `dat_sm` out 16: read data, slave to master.
- `sel` in 2: byte enables; `sel[0]` = bits 7:0, `sel[1]` = bits 15:8.
- `we` in 1: 1 = write, 0 = read.
- `cyc` in 1: bus cycle active.
- `stb` in 1: transfer strobe.
- `ack` out 1: transfer complete, one-cycle pulse.
- `rty` out 1: transfer refused (out of window), one-cycle pulse.

## Operation
- Word offset: `off = (adr - BASE_ADDR) >> 1`, computed in 32 bits.
  - In window iff `adr >= BASE_ADDR` and `off < 2**ADDR_WIDTH`.
  - RAM index = `off[ADDR_WIDTH-1:0]`.
- FSM states: IDLE, RD_WAIT, ACK, RTY.
- IDLE, with `cyc & stb` sampled high:
  - Out of window: go to RTY. No RAM access.
  - Write, in window: write RAM at this edge for each byte with `sel` = 1, then go to ACK.
  - Read, in window: latch the index, load `cnt = READ_LAT-1`.
    - `READ_LAT` = 1: go to ACK.
    - Otherwise: go to RD_WAIT.
- RD_WAIT:
  - `cnt` decrements each cycle.
  - When `cnt` reaches 1, register the RAM word into `dat_sm` and go to ACK.
  - If `cyc` falls, go to IDLE. No ack is issued and `dat_sm` is unchanged.
- ACK: `ack` = 1 for exactly one cycle, then go to IDLE.
- RTY: `rty` = 1 for exactly one cycle, then go to IDLE.
- Because ACK/RTY always return to IDLE, a `stb` still high after `ack` is sampled as a new request.
- A read ignores `sel`: the full word is returned.
- `dat_sm` changes only on a completed read; it holds its value across writes and retries.
- A read of a location written by the immediately preceding transfer returns the new data.
- `ack` and `rty` are never high in the same cycle.

## Timing
- Reset values: `ack` = 0, `rty` = 0, `dat_sm` = 16'h0000, state = IDLE, `cnt` = 0.
- RAM contents are not reset.
- `reset_n` low mid-transfer: all outputs clear immediately (asynchronous). Any pending read is dropped. A write already committed stays committed.
- Request sampled at edge N:
  - Write or out-of-window: `ack`/`rty` high during cycle N+1 to N+2. Throughput is 1 transfer per 2 cycles.
  - Read: `ack` high during cycle N+READ_LAT to N+READ_LAT+1, with `dat_sm` valid in the same cycle. Throughput is 1 per READ_LAT+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `wshb_slave_pkg` holds:
  - `localparam DATA_W = 16`
  - `localparam SEL_W = 2`
  - `typedef enum logic [1:0] {IDLE, RD_WAIT, ACK, RTY} wshb_slv_state_t`
- Sub-module `wshb_ram_be`:
  - single-port synchronous RAM, DATA_W wide, 2**ADDR_WIDTH deep;
  - per-byte write enables, registered read;
  - written to infer M10K.
- Top level contains:
  - the FSM and latency counter;
  - window decode;
  - the `dat_sm` output register.

## Test plan
- Write then read, READ_LAT=2, BASE_ADDR=0:
  - Write `adr`=32'h10, `dat_ms`=16'hBEEF, `sel`=2'b11: `ack` at N+1.
  - Read `adr`=32'h10: `ack` at N+2 with `dat_sm`=16'hBEEF.
- Byte enables:
  - Write 16'h1234 with `sel`=11, then 16'hAB00 with `sel`=10.
  - Read returns 16'hAB34.
- Out of window, ADDR_WIDTH=10, BASE_ADDR=32'h1000:
  - Read at 32'h0FFE: `rty` pulse, `ack` stays 0, `dat_sm` unchanged.
  - Write at 32'h1800: `rty` pulse, RAM unchanged.
- Abort:
  - READ_LAT=4; read issued, `cyc` dropped 2 cycles later.
  - No `ack`, FSM returns to IDLE, the next write is acked normally.
- Back-to-back reads:
  - `stb` held high over addresses 0, 2, 4 holding 16'h1111, 16'h2222, 16'h3333.
  - Exactly three `ack` pulses, spaced READ_LAT+1 cycles, with matching data.
- Reset mid-read:
  - `reset_n` low during RD_WAIT: `ack` = 0 and `dat_sm` = 0 immediately.
  - After release, earlier written data still reads back.
